punc_control_unit: RTL
======================

PUNC_CONTROL_UNIT -- requirements
Module: punc_control_unit

Interface
REQ-001 SHALL have parameter HALT_ON_RESERVED, default 1: opcodes 4'b1000/4'b1101 go to HALT when 1, act as NOP when 0.
REQ-002 SHALL have ports, one per line, as follows:
  clk  in  1  clock; all state changes on posedge.
  rst  in  1  reset, asynchronous, active-high.
  ir  in  16  instruction register contents from datapath.
  halted  out  1  high while in HALT.
  ir_ld  out  1  load IR from memory read port.
  pc_clr  out  1  clear PC (datapath-synchronous).
  pc_up  out  1  increment PC.
  pc_ld  out  1  load PC.
  jmp_ret_jsrr  out  1  PC load source: 1 = ALU output, 0 = PC adder.
  mem_wr_en  out  1  memory write enable.
  mem_r_addr_sel  out  3  read address: 0 PC, 1 PC adder, 2 indirect, 4 ALU.
  state2_sti  out  1  write address: 1 = indirect, 0 = PC adder.
  str  out  1  STR mode: write data = RF port 1, PC adder = ALU.
  rf_wr_en  out  1  register file write enable.
  rf_wr_addr  out  3  register file write index.
  rf_r_addr_0  out  3  RF read index, ALU operand A.
  rf_r_addr_1  out  3  RF read index, ALU operand B.
  rf_w_data_sel  out  2  RF write data: 0 ALU, 1 PC, 2 memory, 3 PC adder.
  alu_sel  out  2  ALU function: 0 PASS, 1 ADD, 2 AND, 3 NOT.
  add_const  out  1  ALU operand B = sign-extended constant.
  sext_select  out  4  extension width: 1000 imm5, 0100 off6, 0010 off9, 0001 off11.
  const_n  out  11  raw constant, zero-padded on the left.
  cc_en  out  1  update N/Z/P from the ALU output.
  n  out  1  branch-on-negative mask.
  z  out  1  branch-on-zero mask.
  p  out  1  branch-on-positive mask.

Function
REQ-003 SHALL be a Moore FSM with states INIT, FETCH, DECODE, EX1, EX2, EX3, HALT.
REQ-004 Every output not named for a state SHALL be 0 in that state.
REQ-005 INIT: assert pc_clr; next state FETCH.
REQ-006 FETCH: assert ir_ld and pc_up, with mem_r_addr_sel=0; next state DECODE.
REQ-007 DECODE: assert no outputs; next state EX1, or HALT for opcode 1111 (or reserved opcodes when HALT_ON_RESERVED=1).
REQ-008 Field definitions used below:
  DR/SR = ir[11:9]; BaseR/SR1 = ir[8:6]; SR2 = ir[2:0].
  off9 sends const_n = ir[8:0]; off6 sends ir[5:0]; imm5 sends ir[4:0]; off11 sends ir[10:0].
REQ-009 ADD/AND/NOT in EX1 SHALL do the following, then go to FETCH:
  rf_r_addr_0=SR1, rf_r_addr_1=SR2.
  add_const=ir[5] and sext_select=1000 (ADD/AND only).
  alu_sel = 1/2/3 respectively; write DR from ALU; cc_en=1.
REQ-010 BR in EX1: {n,z,p}=ir[11:9], off9; then FETCH. The datapath decides whether to take the branch.
REQ-011 n, z, p SHALL be 0 in every state other than EX1 of BR.
REQ-012 JMP in EX1: rf_r_addr_0=BaseR, alu_sel=PASS, jmp_ret_jsrr=1, pc_ld=1; then FETCH.
REQ-013 JSR/JSRR in EX1, then FETCH:
  Both forms write R7 from PC (rf_w_data_sel=1) and assert pc_ld.
  ir[11]=1: off11, jmp_ret_jsrr=0.
  ir[11]=0: BaseR through PASS, jmp_ret_jsrr=1.
REQ-014 LD: EX1 uses mem_r_addr_sel=1 with off9 and writes DR from memory.
REQ-015 LDR: EX1 uses mem_r_addr_sel=4 with BaseR+off6 via ADD (add_const=1) and writes DR from memory.
REQ-016 LEA: EX1 uses off9 and writes DR from the PC adder.
REQ-017 LD/LDR/LEA: EX2 sets rf_r_addr_0=DR, alu_sel=PASS, cc_en=1; then FETCH.
REQ-018 LDI: EX1 uses mem_r_addr_sel=1 with off9, which captures the pointer.
  EX2 uses mem_r_addr_sel=2 and writes DR from memory.
  EX3 sets condition codes as in REQ-017; then FETCH.
REQ-019 ST: EX1 sets rf_r_addr_0=SR, alu_sel=PASS, off9, mem_wr_en=1; then FETCH.
REQ-020 STI: EX1 matches LDI EX1.
  EX2 sets state2_sti=1, rf_r_addr_0=SR, alu_sel=PASS, mem_wr_en=1; then FETCH.
REQ-021 STR: EX1 sets str=1, rf_r_addr_0=BaseR, rf_r_addr_1=SR, add_const=1, off6, alu_sel=ADD, mem_wr_en=1; then FETCH.
REQ-022 HALT SHALL be terminal until rst; halted=1.
REQ-023 Instruction latency in cycles SHALL be: 3 for ADD/AND/NOT/BR/JMP/JSR/ST/STR; 4 for LD/LDR/LEA/STI; 5 for LDI.
REQ-024 Reserved opcodes SHALL pass through EX1 with all outputs 0 when HALT_ON_RESERVED=0.

Reset
REQ-025 rst high SHALL force INIT immediately, mid-instruction included; all outputs 0 except pc_clr=1.
REQ-026 After rst falls, the first posedge SHALL enter FETCH.

Verification
REQ-027 The bench SHALL cover these scenarios:
  Reset release, ir=0x0000 -> INIT, FETCH, DECODE, EX1, with n=z=p=0 in EX1 (BR never taken).
  ir=0x1262 (ADD R1,R1,#2) -> EX1 drives add_const=1, sext_select=1000, const_n=2, rf_wr_addr=1, rf_wr_en=1, cc_en=1.
  ir=0xA404 (LDI R2) -> mem_r_addr_sel goes 1 then 2; DR write in EX2; cc_en in EX3; 5 cycles total.
  ir=0x4803 (JSR +3) -> EX1 has rf_wr_addr=7, rf_w_data_sel=1, pc_ld=1, jmp_ret_jsrr=0, const_n=3, sext_select=0001.
  ir=0xF025 -> HALT with halted=1 held for 10+ cycles; rst pulse in the middle of an LDI EX2 -> INIT with pc_clr=1.

Source files
------------

// File: rtl/punc_control_unit.sv
// PUNC control unit: Moore FSM sequencing fetch, decode and up to
// three execute states for the LC-3 style instruction set.
module punc_control_unit #(
    parameter bit HALT_ON_RESERVED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    output logic        halted,
    output logic        ir_ld,
    output logic        pc_clr,
    output logic        pc_up,
    output logic        pc_ld,
    output logic        jmp_ret_jsrr,
    output logic        mem_wr_en,
    output logic [2:0]  mem_r_addr_sel,
    output logic        state2_sti,
    output logic        str,
    output logic        rf_wr_en,
    output logic [2:0]  rf_wr_addr,
    output logic [2:0]  rf_r_addr_0,
    output logic [2:0]  rf_r_addr_1,
    output logic [1:0]  rf_w_data_sel,
    output logic [1:0]  alu_sel,
    output logic        add_const,
    output logic [3:0]  sext_select,
    output logic [10:0] const_n,
    output logic        cc_en,
    output logic        n,
    output logic        z,
    output logic        p
);

    typedef enum logic [2:0] {
        INIT, FETCH, DECODE, EX1, EX2, EX3, HALT
    } state_t;

    localparam logic [3:0] OP_BR  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_JSR = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_LDR = 4'h6;
    localparam logic [3:0] OP_STR = 4'h7;
    localparam logic [3:0] OP_RS0 = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_STI = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_RS1 = 4'hD;
    localparam logic [3:0] OP_LEA = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    state_t state, state_nx;

    logic [3:0] op;
    logic [2:0] dr;
    logic [2:0] base;
    logic       go_halt;

    assign op   = ir[15:12];
    assign dr   = ir[11:9];
    assign base = ir[8:6];
    assign go_halt = (op == OP_HLT) ||
        (HALT_ON_RESERVED && (op == OP_RS0 || op == OP_RS1));

    // State register; reset forces INIT at once, even mid-instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nx;
    end

    // Next-state and Moore outputs from state plus the held IR
    always_comb begin
        state_nx       = state;
        halted         = 1'b0;
        ir_ld          = 1'b0;
        pc_clr         = 1'b0;
        pc_up          = 1'b0;
        pc_ld          = 1'b0;
        jmp_ret_jsrr   = 1'b0;
        mem_wr_en      = 1'b0;
        mem_r_addr_sel = 3'd0;
        state2_sti     = 1'b0;
        str            = 1'b0;
        rf_wr_en       = 1'b0;
        rf_wr_addr     = 3'd0;
        rf_r_addr_0    = 3'd0;
        rf_r_addr_1    = 3'd0;
        rf_w_data_sel  = 2'd0;
        alu_sel        = 2'd0;
        add_const      = 1'b0;
        sext_select    = 4'b0000;
        const_n        = 11'd0;
        cc_en          = 1'b0;
        n              = 1'b0;
        z              = 1'b0;
        p              = 1'b0;
        unique case (state)
            INIT: begin
                pc_clr   = 1'b1;
                state_nx = FETCH;
            end
            FETCH: begin
                ir_ld    = 1'b1;
                pc_up    = 1'b1;
                state_nx = DECODE;
            end
            DECODE: state_nx = go_halt ? HALT : EX1;
            EX1: begin
                state_nx = FETCH;
                case (op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        rf_r_addr_0 = base;
                        rf_r_addr_1 = ir[2:0];
                        alu_sel     = (op == OP_ADD) ? 2'd1 :
                                      (op == OP_AND) ? 2'd2 : 2'd3;
                        rf_wr_en    = 1'b1;
                        rf_wr_addr  = dr;
                        cc_en       = 1'b1;
                        if (op != OP_NOT) begin
                            add_const   = ir[5];
                            sext_select = 4'b1000;
                            const_n     = {6'd0, ir[4:0]};
                        end
                    end
                    OP_BR: begin
                        {n, z, p}   = ir[11:9];
                        sext_select = 4'b0010;
                        const_n     = {2'd0, ir[8:0]};
                    end
                    OP_JMP: begin
                        rf_r_addr_0  = base;
                        jmp_ret_jsrr = 1'b1;
                        pc_ld        = 1'b1;
                    end
                    OP_JSR: begin
                        rf_wr_en      = 1'b1;
                        rf_wr_addr    = 3'd7;
                        rf_w_data_sel = 2'd1;
                        pc_ld         = 1'b1;
                        if (ir[11]) begin
                            sext_select = 4'b0001;
                            const_n     = ir[10:0];
                        end else begin
                            rf_r_addr_0  = base;
                            jmp_ret_jsrr = 1'b1;
                        end
                    end
                    OP_LD, OP_LEA: begin
                        state_nx      = EX2;
                        sext_select   = 4'b0010;
                        const_n       = {2'd0, ir[8:0]};
                        rf_wr_en      = 1'b1;
                        rf_wr_addr    = dr;
                        mem_r_addr_sel = (op == OP_LD) ? 3'd1 : 3'd0;
                        rf_w_data_sel = (op == OP_LD) ? 2'd2 : 2'd3;
                    end
                    OP_LDR: begin
                        state_nx       = EX2;
                        mem_r_addr_sel = 3'd4;
                        rf_r_addr_0    = base;
                        alu_sel        = 2'd1;
                        add_const      = 1'b1;
                        sext_select    = 4'b0100;
                        const_n        = {5'd0, ir[5:0]};
                        rf_wr_en       = 1'b1;
                        rf_wr_addr     = dr;
                        rf_w_data_sel  = 2'd2;
                    end
                    OP_LDI, OP_STI: begin
                        state_nx       = EX2;
                        mem_r_addr_sel = 3'd1;
                        sext_select    = 4'b0010;
                        const_n        = {2'd0, ir[8:0]};
                    end
                    OP_ST: begin
                        rf_r_addr_0 = dr;
                        sext_select = 4'b0010;
                        const_n     = {2'd0, ir[8:0]};
                        mem_wr_en   = 1'b1;
                    end
                    OP_STR: begin
                        str         = 1'b1;
                        rf_r_addr_0 = base;
                        rf_r_addr_1 = dr;
                        add_const   = 1'b1;
                        sext_select = 4'b0100;
                        const_n     = {5'd0, ir[5:0]};
                        alu_sel     = 2'd1;
                        mem_wr_en   = 1'b1;
                    end
                    default: ;
                endcase
            end
            EX2: begin
                state_nx = FETCH;
                case (op)
                    OP_LD, OP_LDR, OP_LEA: begin
                        rf_r_addr_0 = dr;
                        cc_en       = 1'b1;
                    end
                    OP_LDI: begin
                        state_nx       = EX3;
                        mem_r_addr_sel = 3'd2;
                        rf_wr_en       = 1'b1;
                        rf_wr_addr     = dr;
                        rf_w_data_sel  = 2'd2;
                    end
                    OP_STI: begin
                        state2_sti  = 1'b1;
                        rf_r_addr_0 = dr;
                        mem_wr_en   = 1'b1;
                    end
                    default: ;
                endcase
            end
            EX3: begin
                state_nx    = FETCH;
                rf_r_addr_0 = dr;
                cc_en       = 1'b1;
            end
            HALT: halted = 1'b1;
            default: state_nx = INIT;
        endcase
    end

endmodule
